// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioner: FSM encodings, default timing, synchroniser depth.
package btn_pkg;

   localparam logic [1:0] ST_IDLE         = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
   localparam logic [1:0] ST_PRESSED      = 2'd2;
   localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_REPEAT_DELAY    = 25000000;
   localparam int DEF_REPEAT_PERIOD   = 5000000;
   localparam int SYNC_STAGES         = 2;

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned level/strobe outputs; master drives the buttons, slave is the conditioner.
interface button_conditioner_if #(
   parameter int N_BUTTONS = 3
);
   logic [N_BUTTONS-1:0] BUTTON;
   logic [N_BUTTONS-1:0] HELD;
   logic [N_BUTTONS-1:0] PRESS;
   logic [N_BUTTONS-1:0] RELEASE;

   modport master (output BUTTON, input HELD, input PRESS, input RELEASE);
   modport slave  (input BUTTON, output HELD, output PRESS, output RELEASE);
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop sync, debounce FSM, strobes DEBOUNCE_CYCLES+2 cycles after first sampling edge.
// No backpressure; auto-repeat of PRESS while held exists only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic held,
   output logic press,
   output logic rel
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   smp;
   logic [1:0]             state;
   logic [CW-1:0]          cnt;

`ifdef BTN_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   logic [RW-1:0] rpt;
   logic          rpt_first;
   logic [RW-1:0] rpt_last;

   assign rpt_last = rpt_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
`endif

   // Normalise to pressed=1 after the last synchroniser stage.
   assign smp = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
         state  <= ST_IDLE;
         cnt    <= '0;
         held   <= 1'b0;
         press  <= 1'b0;
         rel    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rpt       <= '0;
         rpt_first <= 1'b1;
`endif
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         press  <= 1'b0;
         rel    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (smp) begin
                  state <= ST_PRESS_WAIT;
                  cnt   <= CW'(1);
               end
            end
            ST_PRESS_WAIT: begin
               if (!smp) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= ST_PRESSED;
                  press <= 1'b1;
                  held  <= 1'b1;
                  cnt   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                  rpt       <= '0;
                  rpt_first <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_PRESSED: begin
               if (!smp) begin
                  state <= ST_RELEASE_WAIT;
                  cnt   <= CW'(1);
               end else begin
`ifdef BTN_AUTOREPEAT_EN
                  // Repeat count only advances on pressed samples, so a bounce resumes where it left off.
                  if (rpt == rpt_last) begin
                     press     <= 1'b1;
                     rpt       <= '0;
                     rpt_first <= 1'b0;
                  end else begin
                     rpt <= rpt + RW'(1);
                  end
`endif
               end
            end
            ST_RELEASE_WAIT: begin
               if (smp) begin
                  state <= ST_PRESSED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= ST_IDLE;
                  rel   <= 1'b1;
                  held  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// N independent debounced button channels on CLOCK_50; registered HELD/PRESS/RELEASE, no backpressure.
// Auto-repeat of PRESS is compiled in only when BTN_AUTOREPEAT_EN is defined.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int N_BUTTONS       = 3,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                 CLOCK_50,
   input  logic                 RESET,
   button_conditioner_if.slave  btn
);

   logic [N_BUTTONS-1:0] held_v;
   logic [N_BUTTONS-1:0] press_v;
   logic [N_BUTTONS-1:0] rel_v;

   for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk   (CLOCK_50),
         .rst   (RESET),
         .raw   (btn.BUTTON[g]),
         .held  (held_v[g]),
         .press (press_v[g]),
         .rel   (rel_v[g])
      );
   end

   assign btn.HELD    = held_v;
   assign btn.PRESS   = press_v;
   assign btn.RELEASE = rel_v;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4; edge k=1 is the first edge sampling a new level.
module tb_button_conditioner;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

`ifdef BTN_AUTOREPEAT_EN
   localparam bit AUTOREP = 1'b1;
`else
   localparam bit AUTOREP = 1'b0;
`endif

   button_conditioner_if #(.N_BUTTONS(3)) bif ();

   button_conditioner #(
      .N_BUTTONS       (3),
      .DEBOUNCE_CYCLES (4),
      .ACTIVE_LOW      (1'b1),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8)
   ) dut (
      .CLOCK_50 (clk),
      .RESET    (rst),
      .btn      (bif)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      bif.BUTTON = 3'b111;
      repeat (3) tick();
      chk("rst_held",    32'(bif.HELD),    32'h0);
      chk("rst_press",   32'(bif.PRESS),   32'h0);
      chk("rst_release", 32'(bif.RELEASE), 32'h0);
      rst = 1'b0;
      repeat (3) tick();

      // Clean press on button 0
      bif.BUTTON[0] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("press0_p%0d", k), 32'(bif.PRESS), (k == 6) ? 32'h1 : 32'h0);
         chk($sformatf("press0_h%0d", k), 32'(bif.HELD),  (k >= 6) ? 32'h1 : 32'h0);
      end

      // Release bounce: high for 2, back low; must not release
      bif.BUTTON[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         if (k == 3) bif.BUTTON[0] = 1'b0;
         tick();
         chk($sformatf("bnc0_r%0d", k), 32'(bif.RELEASE), 32'h0);
         chk($sformatf("bnc0_h%0d", k), 32'(bif.HELD),    32'h1);
      end

      // Final release
      bif.BUTTON[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("rel0_r%0d", k), 32'(bif.RELEASE), (k == 6) ? 32'h1 : 32'h0);
         chk($sformatf("rel0_h%0d", k), 32'(bif.HELD),    (k < 6) ? 32'h1 : 32'h0);
      end

      // Bounce rejection on button 1: low 3 / high 2, five times
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            bif.BUTTON[1] = (c < 3) ? 1'b0 : 1'b1;
            tick();
            chk($sformatf("glitch1_%0d_%0d", r, c),
                32'({bif.PRESS[1], bif.RELEASE[1], bif.HELD[1]}), 32'h0);
         end
      end
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("glitch1_tail%0d", k),
             32'({bif.PRESS[1], bif.RELEASE[1], bif.HELD[1]}), 32'h0);
      end

      // Simultaneous press and release on all channels
      bif.BUTTON = 3'b000;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("all_p%0d", k), 32'(bif.PRESS), (k == 6) ? 32'h7 : 32'h0);
      end
      bif.BUTTON = 3'b111;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("all_r%0d", k), 32'(bif.RELEASE), (k == 6) ? 32'h7 : 32'h0);
         chk($sformatf("all_h%0d", k), 32'(bif.HELD),    (k < 6) ? 32'h7 : 32'h0);
      end

      // Reset mid-debounce: button 0 held, button 2 in PRESS_WAIT
      bif.BUTTON[0] = 1'b0;
      repeat (8) tick();
      chk("pre_rst_held", 32'(bif.HELD), 32'h1);
      bif.BUTTON[2] = 1'b0;
      repeat (4) tick();
      chk("pre_rst_press", 32'(bif.PRESS), 32'h0);
      rst = 1'b1;
      #1;
      chk("midrst_held",    32'(bif.HELD),    32'h0);
      chk("midrst_press",   32'(bif.PRESS),   32'h0);
      chk("midrst_release", 32'(bif.RELEASE), 32'h0);
      repeat (2) tick();
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("postrst_p%0d", k), 32'(bif.PRESS), (k == 6) ? 32'h5 : 32'h0);
         chk($sformatf("postrst_h%0d", k), 32'(bif.HELD),  (k >= 6) ? 32'h5 : 32'h0);
      end
      bif.BUTTON = 3'b111;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("postrst_r%0d", k), 32'(bif.RELEASE), (k == 6) ? 32'h5 : 32'h0);
      end
      repeat (4) tick();

      // Long hold: first PRESS at k=6; repeats at +20 then every 8 when auto-repeat is built in
      bif.BUTTON[0] = 1'b0;
      for (int k = 1; k <= 75; k++) begin
         logic exp_p;
         if (k == 61) bif.BUTTON[0] = 1'b1;
         tick();
         exp_p = (k == 6) ||
                 (AUTOREP && (k == 26 || k == 34 || k == 42 || k == 50 || k == 58));
         chk($sformatf("hold_p%0d", k), 32'(bif.PRESS),   32'(exp_p));
         chk($sformatf("hold_r%0d", k), 32'(bif.RELEASE), (k == 66) ? 32'h1 : 32'h0);
         chk($sformatf("hold_h%0d", k), 32'(bif.HELD),    (k >= 6 && k < 66) ? 32'h1 : 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
